// File: rtl/cam_write_scheduler.sv
// Round-robin write-port scheduler for the block-RAM CAM: arbitrates insert/write/delete
// requests, owns the occupancy bitmap and sequences each CAM write to its completion pulse.
module cam_write_scheduler #(
    parameter int unsigned DATA_WIDTH = 64,
    parameter int unsigned ADDR_WIDTH = 5,
    parameter int unsigned PORTS      = 4,
    localparam int unsigned PW        = (PORTS > 1) ? $clog2(PORTS) : 1
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [PORTS-1:0]           req_valid,
    output logic [PORTS-1:0]           req_ready,
    input  logic [2*PORTS-1:0]         req_op,
    input  logic [PORTS*ADDR_WIDTH-1:0] req_addr,
    input  logic [PORTS*DATA_WIDTH-1:0] req_data,
    output logic                       resp_valid,
    output logic [PW-1:0]              resp_port,
    output logic [ADDR_WIDTH-1:0]      resp_addr,
    output logic [1:0]                 resp_status,
    output logic [ADDR_WIDTH-1:0]      cam_write_addr,
    output logic [DATA_WIDTH-1:0]      cam_write_data,
    output logic                       cam_write_delete,
    output logic                       cam_write_enable,
    input  logic                       cam_write_busy,
    output logic [ADDR_WIDTH:0]        entries_used,
    output logic                       full,
    output logic                       empty
);

    localparam int unsigned Depth = 2 ** ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] FullCount = 1'b1 << ADDR_WIDTH;

    localparam logic [1:0] OpInsert = 2'b00;
    localparam logic [1:0] OpWrite  = 2'b01;
    localparam logic [1:0] OpDelete = 2'b10;

    localparam logic [1:0] StatOk       = 2'b00;
    localparam logic [1:0] StatFull     = 2'b01;
    localparam logic [1:0] StatNotFound = 2'b10;
    localparam logic [1:0] StatBadOp    = 2'b11;

    typedef enum logic [2:0] {StIdle, StIssue, StWaitHi, StWaitLo, StResp} state_t;

    state_t                  state_q;
    logic [PW-1:0]           ptr_q;
    logic [1:0]              op_q;
    logic [Depth-1:0]        occ_q;
    logic [Depth-1:0]        occ_d;
    logic [ADDR_WIDTH:0]     used_d;

    logic                    grant_found;
    logic [PW-1:0]           grant_idx;
    int unsigned             scan_idx;
    logic                    accept;
    logic [1:0]              sel_op;
    logic [ADDR_WIDTH-1:0]   sel_addr;
    logic [DATA_WIDTH-1:0]   sel_data;
    logic                    free_found;
    logic [ADDR_WIDTH-1:0]   free_idx;
    logic                    res_touch;
    logic [1:0]              res_status;
    logic [ADDR_WIDTH-1:0]   res_addr;

    // First valid port at or after the round-robin pointer, wrapping.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        scan_idx    = 0;
        for (int i = 0; i < int'(PORTS); i++) begin
            scan_idx = (32'(ptr_q) + 32'(i)) % PORTS;
            if (!grant_found && req_valid[scan_idx[PW-1:0]]) begin
                grant_found = 1'b1;
                grant_idx   = scan_idx[PW-1:0];
            end
        end
    end

    assign accept = (state_q == StIdle) && grant_found && !cam_write_busy;

    always_comb begin
        req_ready = '0;
        sel_op    = '0;
        sel_addr  = '0;
        sel_data  = '0;
        for (int i = 0; i < int'(PORTS); i++) begin
            if (grant_idx == PW'(i)) begin
                req_ready[i] = accept;
                sel_op       = req_op[i*2 +: 2];
                sel_addr     = req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
                sel_data     = req_data[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    // Downward scan so the last hit is the lowest-index free entry.
    always_comb begin
        free_found = 1'b0;
        free_idx   = '0;
        for (int i = int'(Depth) - 1; i >= 0; i--) begin
            if (!occ_q[i]) begin
                free_found = 1'b1;
                free_idx   = ADDR_WIDTH'(i);
            end
        end
    end

    always_comb begin
        res_touch  = 1'b0;
        res_status = StatOk;
        res_addr   = sel_addr;
        case (sel_op)
            OpInsert: begin
                if (free_found) begin
                    res_addr  = free_idx;
                    res_touch = 1'b1;
                end else begin
                    res_addr   = '0;
                    res_status = StatFull;
                end
            end
            OpWrite: res_touch = 1'b1;
            OpDelete: begin
                if (occ_q[sel_addr]) res_touch = 1'b1;
                else                 res_status = StatNotFound;
            end
            default: res_status = StatBadOp;
        endcase
    end

    // Bitmap commits in the RESP cycle; counters are computed from the committed value.
    always_comb begin
        occ_d = occ_q;
        if (state_q == StResp && resp_status == StatOk) begin
            if (op_q == OpDelete) occ_d[resp_addr] = 1'b0;
            else                  occ_d[resp_addr] = 1'b1;
        end
        used_d = '0;
        for (int i = 0; i < int'(Depth); i++) begin
            used_d = used_d + {{ADDR_WIDTH{1'b0}}, occ_d[i]};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q          <= StIdle;
            ptr_q            <= '0;
            op_q             <= '0;
            occ_q            <= '0;
            resp_valid       <= 1'b0;
            resp_port        <= '0;
            resp_addr        <= '0;
            resp_status      <= '0;
            cam_write_addr   <= '0;
            cam_write_data   <= '0;
            cam_write_delete <= 1'b0;
            cam_write_enable <= 1'b0;
            entries_used     <= '0;
            full             <= 1'b0;
            empty            <= 1'b1;
        end else begin
            cam_write_enable <= 1'b0;
            resp_valid       <= 1'b0;
            occ_q            <= occ_d;
            entries_used     <= used_d;
            full             <= (used_d == FullCount);
            empty            <= (used_d == '0);
            case (state_q)
                StIdle: begin
                    if (accept) begin
                        ptr_q       <= (grant_idx == PW'(PORTS - 1)) ? '0 : grant_idx + 1'b1;
                        op_q        <= sel_op;
                        resp_port   <= grant_idx;
                        resp_addr   <= res_addr;
                        resp_status <= res_status;
                        if (res_touch) begin
                            // Held until the next touching accept; the CAM reads them late.
                            cam_write_addr   <= res_addr;
                            cam_write_data   <= sel_data;
                            cam_write_delete <= (sel_op == OpDelete);
                            cam_write_enable <= 1'b1;
                            state_q          <= StIssue;
                        end else begin
                            resp_valid <= 1'b1;
                            state_q    <= StResp;
                        end
                    end
                end
                StIssue:  state_q <= StWaitHi;
                StWaitHi: if (cam_write_busy) state_q <= StWaitLo;
                StWaitLo: begin
                    if (!cam_write_busy) begin
                        resp_valid <= 1'b1;
                        state_q    <= StResp;
                    end
                end
                StResp:   state_q <= StIdle;
                default:  state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_cam_write_scheduler.sv
// Directed bench for cam_write_scheduler with a behavioural CAM busy model
// (busy 4 cycles after a write, 2 after a delete, plus a forced init-busy).
module tb_cam_write_scheduler;

    localparam int DW = 64;
    localparam int AW = 5;
    localparam int P  = 4;

    localparam logic [1:0] OP_INS = 2'b00;
    localparam logic [1:0] OP_WR  = 2'b01;
    localparam logic [1:0] OP_DEL = 2'b10;
    localparam logic [1:0] OP_BAD = 2'b11;

    localparam logic [1:0] ST_OK   = 2'b00;
    localparam logic [1:0] ST_FULL = 2'b01;
    localparam logic [1:0] ST_NF   = 2'b10;
    localparam logic [1:0] ST_BAD  = 2'b11;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [P-1:0]    req_valid = '0;
    logic [P-1:0]    req_ready;
    logic [2*P-1:0]  req_op = '0;
    logic [P*AW-1:0] req_addr = '0;
    logic [P*DW-1:0] req_data = '0;
    logic            resp_valid;
    logic [1:0]      resp_port;
    logic [AW-1:0]   resp_addr;
    logic [1:0]      resp_status;
    logic [AW-1:0]   cam_write_addr;
    logic [DW-1:0]   cam_write_data;
    logic            cam_write_delete;
    logic            cam_write_enable;
    logic            cam_write_busy;
    logic [AW:0]     entries_used;
    logic            full;
    logic            empty;

    logic init_busy = 1'b1;
    int   busy_cnt = 0;
    int   en_cnt = 0;
    int   resp_cnt = 0;
    int   total = 0;
    int   bad = 0;

    cam_write_scheduler #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .PORTS(P)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_addr(req_addr), .req_data(req_data),
        .resp_valid(resp_valid), .resp_port(resp_port), .resp_addr(resp_addr),
        .resp_status(resp_status),
        .cam_write_addr(cam_write_addr), .cam_write_data(cam_write_data),
        .cam_write_delete(cam_write_delete), .cam_write_enable(cam_write_enable),
        .cam_write_busy(cam_write_busy),
        .entries_used(entries_used), .full(full), .empty(empty)
    );

    always #5 clk = ~clk;

    assign cam_write_busy = init_busy || (busy_cnt != 0);

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n)                busy_cnt <= 0;
        else if (cam_write_enable) busy_cnt <= cam_write_delete ? 2 : 4;
        else if (busy_cnt != 0)    busy_cnt <= busy_cnt - 1;
    end

    always @(posedge clk) begin
        if (cam_write_enable) en_cnt <= en_cnt + 1;
        if (resp_valid)       resp_cnt <= resp_cnt + 1;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_port(input int p, input logic [1:0] op, input logic [AW-1:0] addr,
                            input logic [DW-1:0] data);
        req_op[p*2 +: 2]     = op;
        req_addr[p*AW +: AW] = addr;
        req_data[p*DW +: DW] = data;
        req_valid[p]         = 1'b1;
    endtask

    task automatic wait_accept(input int p, input string tag);
        int n = 0;
        #1;
        while (req_ready == '0 && n < 50) begin
            tick();
            n++;
        end
        chk({tag, "_ready"}, 64'(req_ready), 64'(1 << p));
    endtask

    // Called in the accept cycle; ends in the cycle after RESP.
    task automatic finish_op(input string tag, input int p, input int exp_addr,
                             input logic [1:0] exp_st, input int exp_lat,
                             input logic [1:0] op, input logic [DW-1:0] data);
        int lat;
        tick();
        req_valid[p] = 1'b0;
        lat = 1;
        if (exp_lat > 1) begin
            chk({tag, "_we"}, 64'(cam_write_enable), 64'd1);
            chk({tag, "_waddr"}, 64'(cam_write_addr), 64'(exp_addr));
            chk({tag, "_wdel"}, 64'(cam_write_delete), 64'(op == OP_DEL));
            if (op != OP_DEL) chk({tag, "_wdata"}, cam_write_data, data);
        end
        while (!resp_valid && lat < 20) begin
            tick();
            lat++;
        end
        chk({tag, "_lat"}, 64'(lat), 64'(exp_lat));
        chk({tag, "_port"}, 64'(resp_port), 64'(p));
        if (exp_addr >= 0) chk({tag, "_raddr"}, 64'(resp_addr), 64'(exp_addr));
        chk({tag, "_status"}, 64'(resp_status), 64'(exp_st));
        tick();
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_rv"}, 64'(resp_valid), 64'd0);
        chk({tag, "_we"}, 64'(cam_write_enable), 64'd0);
        chk({tag, "_wdel"}, 64'(cam_write_delete), 64'd0);
        chk({tag, "_waddr"}, 64'(cam_write_addr), 64'd0);
        chk({tag, "_used"}, 64'(entries_used), 64'd0);
        chk({tag, "_full"}, 64'(full), 64'd0);
        chk({tag, "_empty"}, 64'(empty), 64'd1);
        chk({tag, "_ready"}, 64'(req_ready), 64'd0);
    endtask

    initial begin
        int stray;
        int en_before;
        int resp_before;

        // Reset state
        tick();
        tick();
        check_reset_outputs("reset");
        rst_n = 1'b1;

        // Accept held off while the CAM initialises
        set_port(0, OP_INS, '0, 64'h11);
        stray = 0;
        for (int i = 0; i < 512; i++) begin
            #1;
            if (req_ready != '0) stray++;
            tick();
        end
        chk("init_holdoff", 64'(stray), 64'd0);
        init_busy = 1'b0;
        wait_accept(0, "first");
        finish_op("first", 0, 0, ST_OK, 7, OP_INS, 64'h11);
        chk("first_used", 64'(entries_used), 64'd1);
        chk("first_empty", 64'(empty), 64'd0);

        // Fresh reset so the RR pointer is 0, then four simultaneous inserts
        rst_n = 1'b0;
        init_busy = 1'b1;
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) tick();
        init_busy = 1'b0;
        for (int p = 0; p < P; p++) set_port(p, OP_INS, '0, 64'hA0 + 64'(p));
        for (int p = 0; p < P; p++) begin
            wait_accept(p, "rr");
            finish_op("rr", p, p, ST_OK, 7, OP_INS, 64'hA0 + 64'(p));
        end
        chk("rr_used", 64'(entries_used), 64'd4);

        // Pointer back at 0: port 0 wins over port 3
        set_port(0, OP_DEL, 5'd5, '0);
        set_port(3, OP_DEL, 5'd3, '0);
        wait_accept(0, "del_free");
        finish_op("del_free", 0, 5, ST_NF, 1, OP_DEL, '0);
        wait_accept(3, "del_occ");
        finish_op("del_occ", 3, 3, ST_OK, 5, OP_DEL, '0);
        chk("del_used", 64'(entries_used), 64'd3);
        set_port(1, OP_INS, '0, 64'h33);
        wait_accept(1, "reins");
        finish_op("reins", 1, 3, ST_OK, 7, OP_INS, 64'h33);
        chk("reins_used", 64'(entries_used), 64'd4);

        // Overwrite the same address twice
        set_port(2, OP_WR, 5'd7, 64'hAAAA_0000_1111_2222);
        wait_accept(2, "wr_a");
        finish_op("wr_a", 2, 7, ST_OK, 7, OP_WR, 64'hAAAA_0000_1111_2222);
        chk("wr_a_used", 64'(entries_used), 64'd5);
        set_port(3, OP_WR, 5'd7, 64'hBBBB_3333_4444_5555);
        wait_accept(3, "wr_b");
        finish_op("wr_b", 3, 7, ST_OK, 7, OP_WR, 64'hBBBB_3333_4444_5555);
        chk("wr_b_used", 64'(entries_used), 64'd5);

        // Reserved op
        set_port(0, OP_BAD, 5'd9, '0);
        wait_accept(0, "badop");
        finish_op("badop", 0, 9, ST_BAD, 1, OP_BAD, '0);

        // Fill the remaining 27 entries: 4,5,6 then 8..31
        for (int i = 0; i < 27; i++) begin
            set_port(i % P, OP_INS, '0, 64'h1000 + 64'(i));
            wait_accept(i % P, "fill");
            finish_op("fill", i % P, (i < 3) ? 4 + i : i + 5, ST_OK, 7, OP_INS,
                      64'h1000 + 64'(i));
        end
        chk("fill_used", 64'(entries_used), 64'd32);
        chk("fill_full", 64'(full), 64'd1);

        en_before = en_cnt;
        set_port(1, OP_INS, '0, 64'h99);
        wait_accept(1, "full_ins");
        finish_op("full_ins", 1, -1, ST_FULL, 1, OP_INS, 64'h99);
        chk("full_no_we", 64'(en_cnt), 64'(en_before));
        chk("full_used", 64'(entries_used), 64'd32);

        // Reset during WAIT_LO of a delete
        set_port(0, OP_DEL, 5'd10, '0);
        wait_accept(0, "abort");
        tick();
        req_valid[0] = 1'b0;
        tick();
        tick();
        resp_before = resp_cnt;
        rst_n = 1'b0;
        init_busy = 1'b1;
        #1;
        check_reset_outputs("abort");
        tick();
        rst_n = 1'b1;
        set_port(1, OP_INS, '0, 64'h77);
        stray = 0;
        for (int i = 0; i < 20; i++) begin
            #1;
            if (req_ready != '0) stray++;
            tick();
        end
        chk("abort_no_resp", 64'(resp_cnt), 64'(resp_before));
        chk("abort_holdoff", 64'(stray), 64'd0);
        chk("abort_empty", 64'(empty), 64'd1);
        init_busy = 1'b0;
        wait_accept(1, "post");
        finish_op("post", 1, 0, ST_OK, 7, OP_INS, 64'h77);
        chk("post_used", 64'(entries_used), 64'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/cam_write_scheduler.md
# cam_write_scheduler

Shared write-port scheduler for the block-RAM CAM. It arbitrates insert, overwrite and delete requests from `PORTS` independent requesters onto the CAM's single write interface, using round-robin arbitration. It owns the occupancy bitmap, allocates free entries for inserts, sequences each CAM write to completion and returns a per-request response. It sits between the table-management clients and the `cam_bram` write port; the CAM search path is untouched.

## Interface
- `DATA_WIDTH`, 64, key width; must equal the CAM's `DATA_WIDTH`.
- `ADDR_WIDTH`, 5, CAM depth is 2**ADDR_WIDTH entries.
- `PORTS`, 4, number of requesters (≥2); `PW` = $clog2(PORTS).
- `clk`  in  1  single clock.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `req_valid`  in  PORTS  request pending, one bit per port.
- `req_ready`  out  PORTS  one-hot single-cycle accept pulse.
- `req_op`  in  2*PORTS  per-port op: 00 insert (auto-allocate), 01 write at address, 10 delete at address, 11 reserved.
- `req_addr`  in  PORTS*ADDR_WIDTH  per-port target address (ops 01/10).
- `req_data`  in  PORTS*DATA_WIDTH  per-port key (ops 00/01).
- `resp_valid`  out  1  single-cycle completion pulse.
- `resp_port`  out  PW  requester index of the completed request.
- `resp_addr`  out  ADDR_WIDTH  entry written, allocated or deleted.
- `resp_status`  out  2  00 OK, 01 FULL, 10 NOT_FOUND, 11 BAD_OP.
- `cam_write_addr`  out  ADDR_WIDTH  to CAM `write_addr`.
- `cam_write_data`  out  DATA_WIDTH  to CAM `write_data`.
- `cam_write_delete`  out  1  to CAM `write_delete`.
- `cam_write_enable`  out  1  to CAM `write_enable`.
- `cam_write_busy`  in  1  from CAM `write_busy`.
- `entries_used`  out  ADDR_WIDTH+1  popcount of the occupancy bitmap.
- `full`, `empty`  out  1 each  entries_used == 2**ADDR_WIDTH / == 0.

## Operation
- Reset (async, `rst_n`=0):
  - state IDLE, occupancy bitmap all 0, RR pointer 0.
  - All outputs 0 except `empty`=1.
  - CAM tables are re-zeroed by the CAM's own reset, so the two stay consistent.
- Accept:
  - FSM states: IDLE, ISSUE, WAIT_HI, WAIT_LO, RESP.
  - Accept happens only in IDLE, with any `req_valid` set and `cam_write_busy`=0.
  - Grant goes to the first valid port at or after the RR pointer, wrapping.
  - `req_ready[g]`=1 for that one cycle; the RR pointer becomes (g+1) mod PORTS.
  - Op, addr and data for the granted port are latched.
- Resolve, in the accept cycle against the current bitmap:
  - insert: target = lowest-index free entry. If `full`, status FULL and the CAM is not touched.
  - write: target = `req_addr`. Any prior key at that address is replaced; the CAM's erase sequence handles this.
  - delete: if the bit is clear, status NOT_FOUND and the CAM is not touched.
  - op 11: status BAD_OP and the CAM is not touched.
  - Any request that does not touch the CAM goes IDLE→RESP.
- Issue and wait:
  - ISSUE: `cam_write_enable`=1 for exactly one cycle.
  - ISSUE→WAIT_HI; WAIT_HI→WAIT_LO when `cam_write_busy`=1; WAIT_LO→RESP when `cam_write_busy`=0.
- Hold rule: `cam_write_addr`, `cam_write_data` and `cam_write_delete` stay constant from ISSUE through the cycle WAIT_LO exits. The CAM reads `write_addr` unregistered in its later states.
- RESP:
  - `resp_valid`=1 with port, addr and status, then return to IDLE.
  - On OK, update the bitmap in this cycle: insert/write set the bit, delete clears it.
  - `entries_used`, `full` and `empty` are registered and update the cycle after RESP.
- No response backpressure: clients must sink `resp_valid` every cycle.
- Requests whose `req_valid` drops before grant are ignored; `req_valid` need not be held after `req_ready`.

## Timing
- One request in flight; throughput is one accept per operation.
- Accept at cycle T; ISSUE at T+1. The CAM raises busy at T+2.
- Write or insert OK: busy falls at T+6, RESP at T+7, next accept at earliest T+8.
- Delete OK: busy falls at T+4, RESP at T+5.
- CAM not touched (FULL / NOT_FOUND / BAD_OP): RESP at T+1, next accept at T+2.
- After reset, no accept until the CAM's init completes and `cam_write_busy` falls.
- Reset asserted mid-operation: immediate return to IDLE, no response for the aborted request, bitmap cleared.
- Simultaneous requests: exactly one `req_ready` bit per accept, never two.

## Test plan
- After reset, hold `cam_write_busy`=1 for 512 cycles, port0 insert K=0x11 → no `req_ready` until busy falls. Then RESP port0, addr 0, OK; `entries_used`=1.
- All 4 ports request an insert in the same cycle, RR pointer 0 → grants in order 0,1,2,3; addrs 0..3; pointer ends at 0.
- Fill all 32 entries, then insert → RESP FULL one cycle after accept; `cam_write_enable` never pulses; `full`=1.
- Delete addr 5 when the entry is free → NOT_FOUND at T+1. Delete addr 3 when occupied → `cam_write_delete`=1, OK at T+5, `entries_used` decrements. A following insert returns addr 3.
- Write at addr 7 with key A, then write at addr 7 with key B → both OK; the CAM match on A disappears, B matches at 7; `entries_used` rises by only 1.
- Pulse `rst_n` low during WAIT_LO → no `resp_valid`, all outputs 0, `empty`=1, next accept waits for the CAM busy to fall.
